semi_auto_sequencer: RTL and testbench

Sequencer for the car's semi-automatic driving mode. It drives the car forward along a corridor, stops at each intersection or front obstacle, and waits for one user command (left, right or straight). It then times the rotation and the intersection-exit run, and hands back to corridor following. It sits between the debounced button/detector inputs and the motion-command stage, and reports its phase on `state` for the direction/display logic.

---
 rtl/semi_auto_sequencer.sv | 149 ++++++++++++++
 tb/tb_semi_auto_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/semi_auto_sequencer.sv
// Semi-automatic driving sequencer: corridor forward, stop at intersections, timed turn/exit.
// Optional SEMI_AUTO_DEADEND_EN: automatic 180-degree right turn at a dead end when no command arrives.
module semi_auto_sequencer #(
  parameter int TURN_CYCLES = 90_000_000,
  parameter int EXIT_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       det_front,
  input  logic       det_left,
  input  logic       det_right,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       go_straight,
  output logic       move_fwd,
  output logic       rot_left,
  output logic       rot_right,
  output logic [1:0] state,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CMD = 3'd1,
    S_TURN     = 3'd2,
    S_EXIT     = 3'd3,
    S_FORWARD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXIT_LOAD = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] UTURN_LOAD = CNT_W'(2 * TURN_CYCLES - 1);

  state_t           cur_q, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_right_q, dir_right_d;

  logic             move_fwd_d, rot_left_d, rot_right_d, busy_d;
  logic [1:0]       state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= S_IDLE;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      move_fwd    <= 1'b0;
      rot_left    <= 1'b0;
      rot_right   <= 1'b0;
      state       <= 2'b00;
      busy        <= 1'b0;
    end else begin
      cur_q       <= nxt;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
      move_fwd    <= move_fwd_d;
      rot_left    <= rot_left_d;
      rot_right   <= rot_right_d;
      state       <= state_d;
      busy        <= busy_d;
    end
  end

  // Next state, counter and turn direction. Disabling the mode overrides everything.
  always_comb begin
    nxt         = cur_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    if (!enable) begin
      nxt = S_IDLE;
    end else begin
      unique case (cur_q)
        S_IDLE: nxt = S_WAIT_CMD;
        S_WAIT_CMD: begin
          if (turn_left) begin
            nxt         = S_TURN;
            cnt_d       = TURN_LOAD;
            dir_right_d = 1'b0;
          end else if (turn_right) begin
            nxt         = S_TURN;
            cnt_d       = TURN_LOAD;
            dir_right_d = 1'b1;
          end else if (go_straight && !det_front) begin
            nxt   = S_EXIT;
            cnt_d = EXIT_LOAD;
          end
`ifdef SEMI_AUTO_DEADEND_EN
          else if (!go_straight && det_front && det_left && det_right) begin
            nxt         = S_TURN;
            cnt_d       = UTURN_LOAD;
            dir_right_d = 1'b1;
          end
`endif
        end
        S_TURN: begin
          if (cnt_q == '0) begin
            nxt   = S_EXIT;
            cnt_d = EXIT_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_EXIT: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (det_front)          nxt = S_WAIT_CMD;
          else if (cnt_q == '0)   nxt = S_FORWARD;
        end
        S_FORWARD: begin
          if (det_front || !det_left || !det_right) nxt = S_WAIT_CMD;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the transition edge.
  always_comb begin
    move_fwd_d  = 1'b0;
    rot_left_d  = 1'b0;
    rot_right_d = 1'b0;
    state_d     = 2'b00;
    busy_d      = 1'b0;
    unique case (nxt)
      S_FORWARD: begin
        move_fwd_d = 1'b1;
        state_d    = 2'b01;
      end
      S_TURN: begin
        rot_left_d  = !dir_right_d;
        rot_right_d = dir_right_d;
        state_d     = 2'b10;
        busy_d      = 1'b1;
      end
      S_EXIT: begin
        move_fwd_d = !det_front;
        state_d    = 2'b11;
        busy_d     = 1'b1;
      end
      default: ;
    endcase
  end

`ifndef SEMI_AUTO_DEADEND_EN
  logic unused_uturn;
  assign unused_uturn = ^UTURN_LOAD;
`endif

endmodule

// File: tb/tb_semi_auto_sequencer.sv
// Directed bench for semi_auto_sequencer with TURN_CYCLES=4, EXIT_CYCLES=3.
// Dead-end expectations follow SEMI_AUTO_DEADEND_EN when the bench is built with it.
module tb_semi_auto_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, det_front, det_left, det_right;
  logic       turn_left, turn_right, go_straight;
  logic       move_fwd, rot_left, rot_right, busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  semi_auto_sequencer #(.TURN_CYCLES(4), .EXIT_CYCLES(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .det_front(det_front), .det_left(det_left), .det_right(det_right),
    .turn_left(turn_left), .turn_right(turn_right), .go_straight(go_straight),
    .move_fwd(move_fwd), .rot_left(rot_left), .rot_right(rot_right),
    .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector packs {move_fwd, rot_left, rot_right, state, busy}.
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {move_fwd, rot_left, rot_right, state, busy};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got mf/rl/rr/st/busy=%b exp=%b", tag, got, exp);
    end
  endtask

  localparam logic [5:0] O_WAIT  = 6'b000000;
  localparam logic [5:0] O_TL    = 6'b010101;
  localparam logic [5:0] O_TR    = 6'b001101;
  localparam logic [5:0] O_EXIT  = 6'b100111;
  localparam logic [5:0] O_EXIT0 = 6'b000111;
  localparam logic [5:0] O_FWD   = 6'b100010;

  initial begin
    rst_n = 1'b0; enable = 1'b0; det_front = 1'b0; det_left = 1'b1; det_right = 1'b1;
    turn_left = 1'b0; turn_right = 1'b0; go_straight = 1'b0;
    #12;
    chk("reset", O_WAIT);
    tick();
    rst_n = 1'b1;

    // Basic left turn, exit run, corridor following
    enable = 1'b1;
    tick(); chk("wait_e1", O_WAIT);
    tick(); chk("wait_e2", O_WAIT);
    turn_left = 1'b1;
    tick(); chk("turn_l_c1", O_TL);
    turn_left = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick(); chk($sformatf("turn_l_c%0d", i), O_TL);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(); chk($sformatf("exit_c%0d", i), O_EXIT);
    end
    tick(); chk("forward", O_FWD);
    tick(); chk("forward_hold", O_FWD);

    // Intersection stop, then simultaneous left+right commands
    det_right = 1'b0;
    tick(); chk("fwd_stop_right_open", O_WAIT);
    det_right = 1'b1;
    turn_left = 1'b1; turn_right = 1'b1;
    tick(); chk("prio_left_c1", O_TL);
    turn_left = 1'b0; turn_right = 1'b0;
    go_straight = 1'b1; turn_right = 1'b1;
    tick(); chk("turn_ignore_pulse_c2", O_TL);
    go_straight = 1'b0; turn_right = 1'b0;
    tick(); chk("turn_c3", O_TL);
    tick(); chk("turn_c4", O_TL);
    tick(); chk("turn_len_exit", O_EXIT);
    tick(); tick();
    tick(); chk("forward2", O_FWD);

    // Front blocked: straight is refused
    det_front = 1'b1;
    tick(); chk("fwd_stop_front", O_WAIT);
    det_left = 1'b0;
    go_straight = 1'b1;
    tick(); chk("straight_blocked", O_WAIT);
    go_straight = 1'b0;
    det_front = 1'b0; det_left = 1'b1;
    go_straight = 1'b1;
    tick(); chk("straight_exit_c1", O_EXIT);
    go_straight = 1'b0;
    tick(); chk("straight_exit_c2", O_EXIT);
    det_front = 1'b1;
    tick(); chk("exit_cut_front", O_WAIT);

    // Dead end: all detectors set while waiting
    tick();
`ifdef SEMI_AUTO_DEADEND_EN
    chk("deadend_c1", O_TR);
    det_front = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick(); chk($sformatf("deadend_c%0d", i), O_TR);
    end
    tick(); chk("deadend_exit", O_EXIT);
    det_front = 1'b1;
    tick(); chk("deadend_exit_cut", O_WAIT);
    det_front = 1'b0;
`else
    chk("deadend_waits_c1", O_WAIT);
    tick(); chk("deadend_waits_c2", O_WAIT);
    det_front = 1'b0;
`endif

    // Enable drop mid-turn
    turn_right = 1'b1;
    tick(); chk("turn_r_c1", O_TR);
    turn_right = 1'b0;
    tick(); chk("turn_r_c2", O_TR);
    enable = 1'b0;
    tick(); chk("disable_idle", O_WAIT);
    turn_left = 1'b1;
    tick(); chk("idle_ignore_cmd", O_WAIT);
    turn_left = 1'b0;
    enable = 1'b1;
    tick(); chk("reenable_wait", O_WAIT);

    // Asynchronous reset mid-exit
    go_straight = 1'b1;
    tick(); chk("exit_before_rst", O_EXIT);
    go_straight = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mid_exit", O_WAIT);
    #2;
    rst_n = 1'b1;
    tick(); chk("post_rst_wait", O_WAIT);
    turn_left = 1'b1;
    tick(); chk("post_rst_turn", O_TL);
    turn_left = 1'b0;

    // Front obstacle at the TURN->EXIT boundary: exit entered without forward drive
    tick(); tick();
    det_front = 1'b1;
    tick(); chk("turn_c4_front", O_TL);
    tick(); chk("exit_entry_blocked", O_EXIT0);
    tick(); chk("exit_blocked_wait", O_WAIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
